// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front-end. Issues sequential fetch
// addresses under a credit limit, buffers in-order responses with their PCs
// in a circular queue and flushes everything on a branch redirect.
// Optional build macro FETCH_PERF_EN adds the perf_fetched / perf_dropped
// saturating event counters.
module if_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instruction,
    input  logic        out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [63:0]   fetch_pc;
    logic [63:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] occupancy;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic          req_fire;
    logic          push;
    logic          pop;
    logic          queue_nonempty;
    logic [CW:0]   in_flight;
    logic [CW-1:0] outstanding_after_resp;

    // Credit check, handshakes and head presentation.
    always_comb begin
        in_flight              = {1'b0, outstanding} + {1'b0, occupancy};
        imem_req_valid         = !reset && !redirect && (in_flight < (CW+1)'(DEPTH));
        req_fire               = imem_req_valid && imem_req_ready;
        queue_nonempty         = (occupancy != '0);
        out_valid              = !redirect && queue_nonempty;
        pop                    = out_valid && out_ready;
        push                   = imem_resp_valid && !redirect && (discard == '0);
        outstanding_after_resp = outstanding - CW'(imem_resp_valid);
        imem_req_addr          = fetch_pc;
        out_pc                 = queue_nonempty ? pc_mem[head]    : 64'h0;
        out_instruction        = queue_nonempty ? instr_mem[head] : 32'h0;
    end

    // PCs, counters and queue pointers; redirect overrides all other events.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect) begin
            // Everything still in flight after this cycle belongs to the
            // abandoned path and must be swallowed on return.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= outstanding_after_resp;
            discard     <= outstanding_after_resp;
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 64'd4;
            if (push) begin
                resp_pc <= resp_pc + 64'd4;
                tail    <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            if (imem_resp_valid && (discard != '0)) discard <= discard - 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            occupancy   <= occupancy + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; the credit limit guarantees the tail slot is free.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[tail]    <= resp_pc;
            instr_mem[tail] <= imem_resp_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic drop;

    // A response is lost either to a pending discard or to a same-cycle redirect.
    always_comb begin
        drop = imem_resp_valid && (redirect || (discard != '0));
    end

    // Saturating pop and drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (drop && (perf_dropped != '1)) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: the fetch unit against a transaction-level model
// (queues of PCs and words, simple counters) and an in-order memory with
// programmable latency. Directed phases pin the model with literal PCs;
// a random phase mixes ready/backpressure/redirect/reset.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_ready       (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_dropped    (perf_dropped)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        k_reset     = 1'b1;
    logic        k_redirect  = 1'b0;
    logic [63:0] k_rpc       = 64'h0;
    int          k_lat       = 1;
    int          k_ready_pct = 100;
    int          k_ordy_pct  = 100;

    int          mem_due  [$];
    logic [63:0] mem_addr [$];

    logic        m_live = 1'b0;
    logic [63:0] m_fetch, m_resp;
    int          m_outs, m_disc;
    logic [63:0] m_qpc [$];
    logic [31:0] m_qin [$];
    logic [31:0] m_fetched, m_dropped;
    logic [63:0] seq_next;

    logic [63:0] popped  [$];
    int          pop_cyc [$];
    logic        s_req_valid, s_out_valid;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] pop_at(input int i);
        if (i < popped.size()) return popped[i];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic model_reset();
        m_fetch   = RST_PC;
        m_resp    = RST_PC;
        m_outs    = 0;
        m_disc    = 0;
        m_fetched = 0;
        m_dropped = 0;
        m_qpc.delete();
        m_qin.delete();
        mem_due.delete();
        mem_addr.delete();
        seq_next  = RST_PC;
        m_live    = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs, advance model and memory.
    task automatic step();
        logic        rdy, ordy, rv, exp_req_v, exp_out_v;
        logic [31:0] rdata;
        int          due;
        rdy   = ($urandom_range(99) < k_ready_pct);
        ordy  = ($urandom_range(99) < k_ordy_pct);
        rv    = 1'b0;
        rdata = $urandom();
        if (!k_reset && mem_due.size() > 0 && mem_due[0] <= cyc) begin
            rv    = 1'b1;
            rdata = mem_word(mem_addr[0]);
            void'(mem_due.pop_front());
            void'(mem_addr.pop_front());
        end
        reset           = k_reset;
        redirect        = k_redirect;
        redirect_pc     = k_rpc;
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rdata;
        out_ready       = ordy;
        #3;
        exp_req_v   = !k_reset && !k_redirect && (m_outs + m_qpc.size() < DEPTH);
        exp_out_v   = !k_redirect && (m_qpc.size() > 0);
        s_req_valid = imem_req_valid;
        s_out_valid = out_valid;
        if (m_live) begin
            check("imem_req_valid", 64'(imem_req_valid), 64'(exp_req_v));
            check("imem_req_addr", imem_req_addr, m_fetch);
            check("out_valid", 64'(out_valid), 64'(exp_out_v));
            check("out_pc", out_pc, (m_qpc.size() > 0) ? m_qpc[0] : 64'h0);
            check("out_instruction", 64'(out_instruction),
                  64'((m_qin.size() > 0) ? m_qin[0] : 32'h0));
`ifdef FETCH_PERF_EN
            check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
            check("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
`endif
            if (!k_reset && out_valid && ordy) begin
                check("pc_sequence", out_pc, seq_next);
                seq_next = seq_next + 64'd4;
                popped.push_back(out_pc);
                pop_cyc.push_back(cyc);
            end
        end
        if (k_reset) begin
            model_reset();
        end else if (k_redirect) begin
            if (rv) begin
                m_outs--;
                m_dropped++;
            end
            m_disc   = m_outs;
            m_qpc.delete();
            m_qin.delete();
            m_fetch  = k_rpc;
            m_resp   = k_rpc;
            seq_next = k_rpc;
        end else begin
            if (exp_req_v && rdy) begin
                due = cyc + k_lat;
                if (mem_due.size() > 0 && mem_due[$] >= due) due = mem_due[$] + 1;
                mem_due.push_back(due);
                mem_addr.push_back(m_fetch);
                m_outs++;
                m_fetch = m_fetch + 64'd4;
            end
            if (rv) begin
                m_outs--;
                if (m_disc > 0) begin
                    m_disc--;
                    m_dropped++;
                end else begin
                    m_qpc.push_back(m_resp);
                    m_qin.push_back(rdata);
                    m_resp = m_resp + 64'd4;
                end
            end
            if (exp_out_v && ordy) begin
                void'(m_qpc.pop_front());
                void'(m_qin.pop_front());
                m_fetched++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        k_redirect = 1'b1;
        k_rpc      = pc;
        step();
        k_redirect = 1'b0;
    endtask

    initial begin
        int          base, rel;
        logic [31:0] drop0;
        drop0 = 32'h0;

        // Reset and first fetches with single-cycle memory.
        k_reset = 1'b1;
        repeat (3) step();
        k_reset = 1'b0;
        popped.delete();
        pop_cyc.delete();
        rel = cyc;
        repeat (8) step();
        check("first_pop_delay", 64'(pop_cyc.size() > 0 ? pop_cyc[0] - rel : -1), 64'd2);
        check("first_pc", pop_at(0), 64'h100);
        check("second_pc", pop_at(1), 64'h104);
        check("third_pc", pop_at(2), 64'h108);
        check("back_to_back", 64'(pop_cyc.size() > 2 ? pop_cyc[2] - pop_cyc[1] : -1), 64'd1);

        // Backpressure: queue fills, requests stop, stream continues afterwards.
        k_ordy_pct = 0;
        repeat (10) step();
        check("full_req_valid", 64'(s_req_valid), 64'd0);
        check("full_out_valid", 64'(s_out_valid), 64'd1);
        k_ordy_pct = 100;
        repeat (10) step();

        // Redirect with two requests in flight (latency 2).
        k_lat = 2;
        repeat (10) step();
`ifdef FETCH_PERF_EN
        drop0 = perf_dropped;
`endif
        redirect_to(64'h2000);
        base = popped.size();
        repeat (10) step();
        check("redirect_first_pc", pop_at(base), 64'h2000);
        check("redirect_second_pc", pop_at(base + 1), 64'h2004);
`ifdef FETCH_PERF_EN
        check("perf_dropped_delta", 64'(perf_dropped - drop0), 64'd2);
`endif

        // Redirect while a response arrives and a pop is requested.
        k_lat = 1;
        repeat (6) step();
        redirect_to(64'h3000);
        check("redirect_cycle_out_valid", 64'(s_out_valid), 64'd0);
        step();
        check("post_redirect_empty", 64'(s_out_valid), 64'd0);

        // Back-to-back redirects: the last one wins.
        repeat (4) step();
        redirect_to(64'h4000);
        redirect_to(64'h5000);
        base = popped.size();
        repeat (6) step();
        check("last_redirect_wins", pop_at(base), 64'h5000);

        // Address wrap at the top of the 64-bit space.
        redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
        base = popped.size();
        repeat (8) step();
        check("wrap_pc0", pop_at(base), 64'hFFFF_FFFF_FFFF_FFF8);
        check("wrap_pc1", pop_at(base + 1), 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc2", pop_at(base + 2), 64'h0);
        check("wrap_pc3", pop_at(base + 3), 64'h4);

        // Random mix: latency 3, random ready/backpressure, redirects, one reset.
        k_lat       = 3;
        k_ready_pct = 50;
        k_ordy_pct  = 70;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) k_lat = 1;
            k_reset    = (i == 250 || i == 251);
            k_redirect = !k_reset && ($urandom_range(99) < 4);
            k_rpc      = {$urandom(), $urandom()} & ~64'h3;
            step();
        end
        k_reset    = 1'b0;
        k_redirect = 1'b0;
        k_ordy_pct = 100;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
